// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe bus: fetch-side valid/ready input and decode-side valid/ready output.
// slave = the generator, master = whoever drives instructions and drains results.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;
  logic [15:0]     illegal_count;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt,
    output out_target, out_illegal, illegal_count
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt,
    input  out_target, out_illegal, illegal_count
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a one-entry skid buffer.
// Ports: clk, reset (async, active-high), bus (slave side of imm_gen_pipe_if).
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter bit SUPPORT_CSR = 1'b1
) (
  input logic          clk,
  input logic          reset,
  imm_gen_pipe_if.slave bus
);
  localparam logic [2:0] F_NONE = 3'd0;
  localparam logic [2:0] F_I    = 3'd1;
  localparam logic [2:0] F_S    = 3'd2;
  localparam logic [2:0] F_B    = 3'd3;
  localparam logic [2:0] F_U    = 3'd4;
  localparam logic [2:0] F_J    = 3'd5;
  localparam logic [2:0] F_Z    = 3'd6;
  localparam logic [2:0] F_SH   = 3'd7;
  localparam bit X64 = (XLEN == 64);

  typedef struct packed {
    logic            ill;
    logic [XLEN-1:0] tgt;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
  } ent_t;

  logic [31:0]     ins;
  logic [6:0]      op;
  logic [2:0]      f3;
  logic            sh;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] imm_z, sh5, sh6, imm;
  logic [2:0]      fmt;
  logic            ill, pcrel;
  ent_t            dec;

  assign ins = bus.in_instr;
  assign op  = ins[6:0];
  assign f3  = ins[14:12];
  assign sh  = (f3 == 3'b001) || (f3 == 3'b101);

  assign imm_i = XLEN'($signed(ins[31:20]));
  assign imm_s = XLEN'($signed({ins[31:25], ins[11:7]}));
  assign imm_b = XLEN'($signed({ins[31], ins[7], ins[30:25],
                                ins[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({ins[31], ins[19:12], ins[20],
                                ins[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({ins[31:12], 12'b0}));
  assign imm_z = XLEN'(ins[19:15]);
  assign sh5   = XLEN'(ins[24:20]);
  assign sh6   = XLEN'(ins[25:20]);

  always_comb begin
    fmt   = F_NONE;
    imm   = '0;
    ill   = 1'b0;
    pcrel = 1'b0;
    if (ins[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      unique case (op)
        7'b0000011, 7'b1100111, 7'b0001111: begin
          fmt = F_I;
          imm = imm_i;
        end
        7'b0010011: begin
          if (!sh) begin
            fmt = F_I;
            imm = imm_i;
          end else if (!X64 && ins[25]) begin
            ill = 1'b1;
          end else begin
            fmt = F_SH;
            imm = X64 ? sh6 : sh5;
          end
        end
        7'b0011011: begin
          if (!X64 || (sh && ins[25])) begin
            ill = 1'b1;
          end else if (sh) begin
            fmt = F_SH;
            imm = sh5;
          end else begin
            fmt = F_I;
            imm = imm_i;
          end
        end
        7'b0100011: begin
          fmt = F_S;
          imm = imm_s;
        end
        7'b1100011: begin
          fmt   = F_B;
          imm   = imm_b;
          pcrel = 1'b1;
        end
        7'b1101111: begin
          fmt   = F_J;
          imm   = imm_j;
          pcrel = 1'b1;
        end
        7'b0110111: begin
          fmt = F_U;
          imm = imm_u;
        end
        7'b0010111: begin
          fmt   = F_U;
          imm   = imm_u;
          pcrel = 1'b1;
        end
        7'b1110011: begin
          if (f3 != 3'b000) begin
            if (SUPPORT_CSR) begin
              fmt = F_Z;
              imm = imm_z;
            end else begin
              ill = 1'b1;
            end
          end
        end
        7'b0110011: ill = 1'b0;
        7'b0111011: ill = !X64;
        default:    ill = 1'b1;
      endcase
    end
    dec.ill = ill;
    dec.fmt = ill ? F_NONE : fmt;
    dec.imm = ill ? '0 : imm;
    dec.tgt = (pcrel && !ill) ? bus.in_pc + imm : '0;
  end

  ent_t        oreg, oreg_n, sreg, sreg_n;
  logic        ov, ov_n, sv, sv_n, rdy;
  logic        acc, drain;
  logic [15:0] cnt;

  assign acc   = bus.in_valid && rdy;
  assign drain = ov && bus.out_ready;

  // rdy is the registered !skid_valid, so acc never coincides with sv=1.
  always_comb begin
    oreg_n = oreg;
    sreg_n = sreg;
    ov_n   = ov;
    sv_n   = sv;
    if (!ov || drain) begin
      if (sv) begin
        oreg_n = sreg;
        ov_n   = 1'b1;
        sv_n   = 1'b0;
      end else if (acc) begin
        oreg_n = dec;
        ov_n   = 1'b1;
      end else begin
        ov_n   = 1'b0;
      end
    end else if (acc) begin
      sreg_n = dec;
      sv_n   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oreg <= '0;
      sreg <= '0;
      ov   <= 1'b0;
      sv   <= 1'b0;
      rdy  <= 1'b0;
      cnt  <= '0;
    end else begin
      oreg <= oreg_n;
      sreg <= sreg_n;
      ov   <= ov_n;
      sv   <= sv_n;
      rdy  <= !sv_n;
      if (drain && oreg.ill && cnt != 16'hFFFF)
        cnt <= cnt + 16'd1;
    end
  end

  assign bus.in_ready      = rdy;
  assign bus.out_valid     = ov;
  assign bus.out_imm       = oreg.imm;
  assign bus.out_fmt       = oreg.fmt;
  assign bus.out_target    = oreg.tgt;
  assign bus.out_illegal   = oreg.ill;
  assign bus.illegal_count = cnt;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven in lockstep.
// Directed test-plan steps, then random traffic against a reference model.
module tb_imm_gen_pipe;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        iv, orr;
  logic [31:0] ins;
  logic [63:0] pc;

  imm_gen_pipe_if #(.XLEN(32)) b32();
  imm_gen_pipe_if #(.XLEN(64)) b64();

  assign b32.in_valid  = iv;
  assign b32.in_instr  = ins;
  assign b32.in_pc     = pc[31:0];
  assign b32.out_ready = orr;
  assign b64.in_valid  = iv;
  assign b64.in_instr  = ins;
  assign b64.in_pc     = pc;
  assign b64.out_ready = orr;

  imm_gen_pipe #(.XLEN(32), .SUPPORT_CSR(1'b1)) u32 (
    .clk(clk), .reset(reset), .bus(b32)
  );
  imm_gen_pipe #(.XLEN(64), .SUPPORT_CSR(1'b1)) u64 (
    .clk(clk), .reset(reset), .bus(b64)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] tgt;
    logic        ill;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   ndel = 0;
  int   mc32 = 0;
  int   mc64 = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input longint v, input int bits);
    longint half;
    half = longint'(1) << (bits - 1);
    return (v >= half) ? v - (half * 2) : v;
  endfunction

  // Reference decode: field extraction with integer arithmetic.
  function automatic exp_t model(input logic [31:0] i,
                                 input logic [63:0] p, input bit x64);
    exp_t   e;
    longint v;
    int     f, op, f3;
    bit     pcr, il, shf;
    logic [63:0] m;
    v = 0; f = 0; pcr = 0; il = 0;
    op  = int'(i[6:0]);
    f3  = int'(i[14:12]);
    shf = (f3 == 1) || (f3 == 5);
    m   = x64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    if (i[1:0] != 2'b11) il = 1;
    else case (op)
      'h03, 'h67, 'h0F: begin f = 1; v = sx(longint'(i[31:20]), 12); end
      'h13: if (!shf) begin
              f = 1; v = sx(longint'(i[31:20]), 12);
            end else if (!x64 && i[25]) il = 1;
            else begin
              f = 7;
              v = x64 ? longint'(i[25:20]) : longint'(i[24:20]);
            end
      'h1B: if (!x64) il = 1;
            else if (!shf) begin f = 1; v = sx(longint'(i[31:20]), 12); end
            else if (i[25]) il = 1;
            else begin f = 7; v = longint'(i[24:20]); end
      'h23: begin
              f = 2;
              v = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
            end
      'h63: begin
              f = 3; pcr = 1;
              v = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
                     longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
            end
      'h6F: begin
              f = 5; pcr = 1;
              v = sx(longint'(i[31]) * 1048576 +
                     longint'(i[19:12]) * 4096 +
                     longint'(i[20]) * 2048 +
                     longint'(i[30:21]) * 2, 21);
            end
      'h37: begin f = 4; v = sx(longint'(i[31:12]) * 4096, 32); end
      'h17: begin f = 4; pcr = 1; v = sx(longint'(i[31:12]) * 4096, 32); end
      'h73: if (f3 != 0) begin f = 6; v = longint'(i[19:15]); end
      'h33: f = 0;
      'h3B: il = !x64;
      default: il = 1;
    endcase
    if (il) begin
      e.imm = '0; e.fmt = '0; e.tgt = '0; e.ill = 1'b1;
    end else begin
      e.imm = 64'(v) & m;
      e.fmt = 3'(f);
      e.tgt = pcr ? ((p + 64'(v)) & m) : 64'd0;
      e.ill = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q32.delete();
      q64.delete();
      mc32 = 0;
      mc64 = 0;
    end else begin
      if (b32.out_valid && orr) begin
        ndel++;
        chk("cnt32", 64'(b32.illegal_count), 64'(mc32));
        if (q32.size() == 0) chk("q32_empty", 64'd1, 64'd0);
        else begin
          e = q32.pop_front();
          chk("d32_imm", 64'(b32.out_imm), e.imm);
          chk("d32_fmt", 64'(b32.out_fmt), 64'(e.fmt));
          chk("d32_tgt", 64'(b32.out_target), e.tgt);
          chk("d32_ill", 64'(b32.out_illegal), 64'(e.ill));
          if (e.ill && mc32 < 65535) mc32++;
        end
      end
      if (b64.out_valid && orr) begin
        chk("cnt64", 64'(b64.illegal_count), 64'(mc64));
        if (q64.size() == 0) chk("q64_empty", 64'd1, 64'd0);
        else begin
          e = q64.pop_front();
          chk("d64_imm", b64.out_imm, e.imm);
          chk("d64_fmt", 64'(b64.out_fmt), 64'(e.fmt));
          chk("d64_tgt", b64.out_target, e.tgt);
          chk("d64_ill", 64'(b64.out_illegal), 64'(e.ill));
          if (e.ill && mc64 < 65535) mc64++;
        end
      end
      if (iv && b32.in_ready) q32.push_back(model(ins, {32'b0, pc[31:0]}, 1'b0));
      if (iv && b64.in_ready) q64.push_back(model(ins, pc, 1'b1));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0]  ops [13];
    logic [31:0] r;
    ops = '{7'h03, 7'h67, 7'h0F, 7'h13, 7'h1B, 7'h23, 7'h63,
            7'h6F, 7'h37, 7'h17, 7'h73, 7'h33, 7'h3B};
    r = $urandom;
    if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 12)];
    return r;
  endfunction

  int  n0;
  bit  accd;

  initial begin
    iv = 0; orr = 0; ins = '0; pc = '0; reset = 1'b1;
    #2;
    chk("rst_rdy32", 64'(b32.in_ready), 64'd0);
    chk("rst_ov32", 64'(b32.out_valid), 64'd0);
    chk("rst_imm32", 64'(b32.out_imm), 64'd0);
    chk("rst_fmt32", 64'(b32.out_fmt), 64'd0);
    chk("rst_tgt32", 64'(b32.out_target), 64'd0);
    chk("rst_ill32", 64'(b32.out_illegal), 64'd0);
    chk("rst_cnt32", 64'(b32.illegal_count), 64'd0);
    chk("rst_ov64", 64'(b64.out_valid), 64'd0);
    tick;
    chk("rdy_in_rst", 64'(b32.in_ready), 64'd0);
    reset = 1'b0;
    tick;
    chk("rdy_rise32", 64'(b32.in_ready), 64'd1);
    chk("rdy_rise64", 64'(b64.in_ready), 64'd1);

    orr = 1; iv = 1; ins = 32'h00A10093; pc = 64'h0;
    tick;
    chk("addi_ov", 64'(b32.out_valid), 64'd1);
    chk("addi_fmt", 64'(b32.out_fmt), 64'd1);
    chk("addi_imm", 64'(b32.out_imm), 64'h0000000A);
    chk("addi_tgt", 64'(b32.out_target), 64'd0);
    chk("addi_ill", 64'(b32.out_illegal), 64'd0);
    ins = 32'h0030A623;
    tick;
    chk("sw_fmt", 64'(b32.out_fmt), 64'd2);
    chk("sw_imm", 64'(b32.out_imm), 64'h0000000C);
    ins = 32'hFE0008E3; pc = 64'h100;
    tick;
    chk("beq_fmt", 64'(b32.out_fmt), 64'd3);
    chk("beq_imm", 64'(b32.out_imm), 64'hFFFFFFF0);
    chk("beq_tgt", 64'(b32.out_target), 64'hF0);
    chk("beq_imm64", b64.out_imm, 64'hFFFFFFFF_FFFFFFF0);
    chk("beq_tgt64", b64.out_target, 64'hF0);
    ins = 32'h02109093; pc = 64'h0;
    tick;
    chk("slli32_ill", 64'(b32.out_illegal), 64'd1);
    chk("slli32_fmt", 64'(b32.out_fmt), 64'd0);
    chk("slli32_imm", 64'(b32.out_imm), 64'd0);
    chk("slli64_fmt", 64'(b64.out_fmt), 64'd7);
    chk("slli64_imm", b64.out_imm, 64'd33);
    ins = 32'h800000B7;
    tick;
    chk("slli32_cnt", 64'(b32.illegal_count), 64'd1);
    chk("slli64_cnt", 64'(b64.illegal_count), 64'd0);
    chk("lui64_fmt", 64'(b64.out_fmt), 64'd4);
    chk("lui64_imm", b64.out_imm, 64'hFFFFFFFF_80000000);
    chk("lui32_imm", 64'(b32.out_imm), 64'h80000000);
    ins = 32'h12345073;
    tick;
    chk("csr64_fmt", 64'(b64.out_fmt), 64'd6);
    chk("csr64_imm", b64.out_imm, 64'd8);
    iv = 0;
    tick;
    tick;
    chk("idle_ov", 64'(b32.out_valid), 64'd0);

    n0 = ndel;
    orr = 0; iv = 1; ins = 32'h00100093;
    tick;
    ins = 32'h00200093;
    tick;
    chk("bp_rdy_low", 64'(b32.in_ready), 64'd0);
    chk("bp_holdA", 64'(b32.out_imm), 64'd1);
    ins = 32'h00300093;
    tick;
    chk("bp_stall_rdy", 64'(b32.in_ready), 64'd0);
    chk("bp_stall_ov", 64'(b32.out_valid), 64'd1);
    chk("bp_stall_A", 64'(b32.out_imm), 64'd1);
    orr = 1;
    tick;
    chk("bp_B", 64'(b32.out_imm), 64'd2);
    chk("bp_rdy_back", 64'(b32.in_ready), 64'd1);
    tick;
    chk("bp_C", 64'(b32.out_imm), 64'd3);
    iv = 0;
    tick;
    chk("bp_done_ov", 64'(b32.out_valid), 64'd0);
    chk("bp_count", 64'(ndel - n0), 64'd3);

    accd = 1;
    for (int k = 0; k < 400; k++) begin
      if (!iv || accd) begin
        iv  = ($urandom_range(0, 3) != 0);
        ins = rnd_instr();
        pc  = {$urandom, $urandom};
      end
      orr  = ($urandom_range(0, 2) != 0);
      accd = iv && b32.in_ready;
      tick;
    end
    iv = 0; orr = 1;
    repeat (4) tick;
    chk("rnd_q32_left", 64'(q32.size()), 64'd0);
    chk("rnd_q64_left", 64'(q64.size()), 64'd0);

    orr = 0; iv = 1; ins = 32'h00500093; pc = 64'h0;
    tick;
    ins = 32'h00600093;
    tick;
    iv = 0;
    chk("pre_rst_ov", 64'(b32.out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_ov", 64'(b32.out_valid), 64'd0);
    chk("ar_imm", 64'(b32.out_imm), 64'd0);
    chk("ar_fmt", 64'(b32.out_fmt), 64'd0);
    chk("ar_ill", 64'(b32.out_illegal), 64'd0);
    chk("ar_cnt32", 64'(b32.illegal_count), 64'd0);
    chk("ar_cnt64", 64'(b64.illegal_count), 64'd0);
    chk("ar_rdy", 64'(b32.in_ready), 64'd0);
    chk("ar_ov64", 64'(b64.out_valid), 64'd0);
    tick;
    reset = 1'b0;
    chk("ar_rdy_hold", 64'(b32.in_ready), 64'd0);
    tick;
    chk("ar_rdy_rise", 64'(b32.in_ready), 64'd1);
    chk("ar_no_stale", 64'(b32.out_valid), 64'd0);
    orr = 1;
    tick;
    chk("ar_no_stale2", 64'(b32.out_valid), 64'd0);
    chk("ar_no_stale64", 64'(b64.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
